spram_16kx16: RTL and testbench
===============================

// Module: spram_16kx16
// PURPOSE
//  Behavioural single-port synchronous RAM, 16384 x 16 bit, with nibble write masks and low-power controls.
//  Pin-compatible with the iCE40UP SPRAM primitive.
//  Two instances side by side form the 32-bit frame buffer behind the LED matrix Wishbone slave.
//  The LED scan engine and the bus share each instance through an external address/data mux.
// PARAMETERS
//  ADDR_W   14  word address width (depth = 2**ADDR_W)
//  DATA_W   16  data width; must be a multiple of 4 (one MASKWREN bit per nibble)
//  MASK_W   4   DATA_W/4, number of nibble write-enable bits
// PORTS
//  wb_clk_i    in   1       single clock; all state updates on rising edge
//  wb_reset_i  in   1       reset, synchronous, active-low (0 = reset)
//  ADDRESS     in   ADDR_W  word address
//  DATAIN      in   DATA_W  write data
//  MASKWREN    in   MASK_W  per-nibble write enable; bit i covers DATAIN[4i+3:4i]
//  WREN        in   1       1 = write cycle, 0 = read cycle
//  CHIPSELECT  in   1       1 = access enabled; 0 = no access, DATAOUT holds
//  STANDBY     in   1       1 = no access, DATAOUT holds, contents retained
//  SLEEP       in   1       1 = no access, DATAOUT forced 0, contents retained
//  POWEROFF    in   1       active-low power gate; 0 = powered down, DATAOUT forced 0
//  DATAOUT     out  DATA_W  registered read data
// BEHAVIOUR
//  - Reset (wb_reset_i=0 at a clock edge): DATAOUT <= 0; no write occurs that cycle.
//    Memory contents are not touched. Reset has priority over every other input.
//  - Memory array is zero-initialised at time 0 (simulation and bitstream init).
//  - Active condition: CHIPSELECT=1 & STANDBY=0 & SLEEP=0 & POWEROFF=1.
//  - Priority per edge, highest first:
//      1. reset
//      2. POWEROFF=0 or SLEEP=1: DATAOUT <= 0
//      3. not active: DATAOUT holds
//      4. active write
//      5. active read
//  - Write (active, WREN=1): for each i with MASKWREN[i]=1, mem[ADDRESS][4i+3:4i] <= DATAIN[4i+3:4i].
//    Nibbles with MASKWREN[i]=0 are unchanged. MASKWREN=0 writes nothing.
//    DATAOUT holds its previous value on a write cycle (no write-through).
//  - Read (active, WREN=0): DATAOUT <= mem[ADDRESS]. Latency 1 cycle.
//    Data is valid after the edge that samples ADDRESS, and held until the next read, sleep, power-off or reset.
//  - Write then read of the same address on the next cycle returns the new data; no extra hazard cycle.
//  - Address is used modulo 2**ADDR_W; no out-of-range behaviour exists.
//  - Power-off: contents are retained in this model. Software must treat them as undefined after POWEROFF=0.
//    Verification must not check contents across a power-off.
//  - No handshake and no busy state: every active cycle completes in one clock.
//  - Inputs are sampled only at the rising edge; no combinational path from any input to DATAOUT.
// TESTING
//  1. Reset: drive wb_reset_i=0 with DATAOUT previously 0xBEEF -> DATAOUT=0x0000 next edge.
//     Re-read the address that held 0xBEEF -> 0xBEEF still stored.
//  2. Full write/read: write 0x1234 @0x0000 and 0xA5C3 @0x3FFF (MASKWREN=F).
//     Read both -> 0x1234 and 0xA5C3, each one cycle after the address is presented.
//  3. Nibble mask: @0x0100 write 0xFFFF (mask F), then 0x0000 with mask 0101b -> read 0xF0F0.
//     Then 0x1234 with mask 0000 -> still 0xF0F0.
//  4. Write cycle output hold: read @0x0000 -> DATAOUT=0x1234.
//     Next cycle write 0x9999 @0x0000 -> DATAOUT stays 0x1234.
//     Next read -> 0x9999.
//  5. Low power: CHIPSELECT=0 or STANDBY=1 with WREN=1 -> no write, DATAOUT holds.
//     SLEEP=1 -> DATAOUT=0; POWEROFF=0 -> DATAOUT=0.
//     After SLEEP=0, read @0x0100 -> 0xF0F0 (retained).
//  6. Back-to-back: 16 consecutive reads of addresses 0x10..0x1F, preloaded with value = address.
//     DATAOUT sequence equals the addresses, delayed one cycle.

Source files
------------

// File: rtl/spram_16kx16.sv
// spram_16kx16 -- behavioural single-port synchronous RAM, 16384 x 16 bit.
// Pin-compatible with the iCE40UP SPRAM primitive. It has nibble write masks
// and low-power controls. Two instances form the 32-bit LED frame buffer.
//
// Ports
//   wb_clk_i    single clock; all state updates on the rising edge
//   wb_reset_i  synchronous active-low reset; clears DATAOUT only
//   ADDRESS     word address
//   DATAIN      write data
//   MASKWREN    per-nibble write enable; bit i covers DATAIN[4i+3:4i]
//   WREN        1 = write cycle, 0 = read cycle
//   CHIPSELECT  1 = access enabled
//   STANDBY     1 = no access, DATAOUT holds
//   SLEEP       1 = no access, DATAOUT forced to 0
//   POWEROFF    active-low power gate; 0 = DATAOUT forced to 0
//   DATAOUT     registered read data, one cycle latency
module spram_16kx16 #(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned MASK_W = DATA_W / 4
) (
  input  logic              wb_clk_i,
  input  logic              wb_reset_i,
  input  logic [ADDR_W-1:0] ADDRESS,
  input  logic [DATA_W-1:0] DATAIN,
  input  logic [MASK_W-1:0] MASKWREN,
  input  logic              WREN,
  input  logic              CHIPSELECT,
  input  logic              STANDBY,
  input  logic              SLEEP,
  input  logic              POWEROFF,
  output logic [DATA_W-1:0] DATAOUT
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  // Zero-initialised array; never reset, contents survive every low-power mode.
  logic [DATA_W-1:0] mem_q [DEPTH] = '{default: '0};
  logic [DATA_W-1:0] dataout_q;
  logic [DATA_W-1:0] dataout_d;
  logic [DATA_W-1:0] wdata_d;
  logic              active;
  logic              wr_en;

  always_comb begin
    active = CHIPSELECT && !STANDBY && !SLEEP && POWEROFF;
    // Reset suppresses the write on the same edge.
    wr_en  = wb_reset_i && active && WREN;

    // The masked write is built as a read-modify-write of the whole word,
    // so the array only ever sees full-word updates.
    wdata_d = mem_q[ADDRESS];
    for (int unsigned i = 0; i < MASK_W; i++) begin
      if (MASKWREN[i]) begin
        wdata_d[4*i +: 4] = DATAIN[4*i +: 4];
      end
    end

    // Priority: power-off/sleep clear, then inactive hold, then write hold,
    // then read.
    dataout_d = dataout_q;
    if (!POWEROFF || SLEEP) begin
      dataout_d = '0;
    end else if (active && !WREN) begin
      dataout_d = mem_q[ADDRESS];
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_reset_i) begin
      dataout_q <= '0;
    end else begin
      dataout_q <= dataout_d;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wr_en) begin
      mem_q[ADDRESS] <= wdata_d;
    end
  end

  assign DATAOUT = dataout_q;

endmodule

// File: tb/tb_spram_16kx16.sv
module tb_spram_16kx16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [13:0] addr = '0;
  logic [15:0] din = '0;
  logic [3:0]  mask = '0;
  logic        we = 1'b0;
  logic        cs = 1'b0;
  logic        sb = 1'b0;
  logic        sl = 1'b0;
  logic        po = 1'b1;
  logic [15:0] dout;

  int checks = 0;
  int errors = 0;

  // Reference model: plain array plus the expected output word.
  logic [15:0] ref_mem [16384] = '{default: '0};
  logic [15:0] exp_dout = '0;

  always #5 clk = ~clk;

  spram_16kx16 #(.ADDR_W(14), .DATA_W(16), .MASK_W(4)) dut (
    .wb_clk_i   (clk),
    .wb_reset_i (rst_n),
    .ADDRESS    (addr),
    .DATAIN     (din),
    .MASKWREN   (mask),
    .WREN       (we),
    .CHIPSELECT (cs),
    .STANDBY    (sb),
    .SLEEP      (sl),
    .POWEROFF   (po),
    .DATAOUT    (dout)
  );

  // One clock: drive on the falling edge, apply the rules at the rising edge,
  // and return 1 time unit after it so outputs can be sampled.
  task automatic step(input logic r, input logic c, input logic w, input logic s,
                      input logic z, input logic p, input logic [13:0] a,
                      input logic [15:0] d, input logic [3:0] m);
    @(negedge clk);
    rst_n = r; cs = c; we = w; sb = s; sl = z; po = p; addr = a; din = d; mask = m;
    @(posedge clk);
    if (!r) begin
      exp_dout = 16'h0000;
    end else if (!p || z) begin
      exp_dout = 16'h0000;
    end else if (!c || s) begin
      exp_dout = exp_dout;
    end else if (w) begin
      for (int i = 0; i < 4; i++)
        if (m[i]) ref_mem[a][i*4 +: 4] = d[i*4 +: 4];
    end else begin
      exp_dout = ref_mem[a];
    end
    #1;
  endtask

  task automatic wr(input logic [13:0] a, input logic [15:0] d, input logic [3:0] m);
    step(1, 1, 1, 0, 0, 1, a, d, m);
  endtask

  task automatic rd(input logic [13:0] a);
    step(1, 1, 0, 0, 0, 1, a, 16'h0000, 4'h0);
  endtask

  task automatic test_reset;
    step(0, 0, 0, 0, 0, 1, 14'h0, 16'h0, 4'h0);
    step(0, 0, 0, 0, 0, 1, 14'h0, 16'h0, 4'h0);
    checks++;
    if (dout !== 16'h0000) begin errors++; $display("FAIL reset_init got %h expected 0000", dout); end
    wr(14'h0200, 16'hBEEF, 4'hF);
    rd(14'h0200);
    checks++;
    if (dout !== 16'hBEEF) begin errors++; $display("FAIL reset_preload got %h expected beef", dout); end
    // Reset with a write request pending: output clears and the write is dropped.
    step(0, 1, 1, 0, 0, 1, 14'h0200, 16'h0000, 4'hF);
    checks++;
    if (dout !== 16'h0000) begin errors++; $display("FAIL reset_clear got %h expected 0000", dout); end
    rd(14'h0200);
    checks++;
    if (dout !== 16'hBEEF) begin errors++; $display("FAIL reset_retain got %h expected beef", dout); end
  endtask

  task automatic test_full_rw;
    wr(14'h0000, 16'h1234, 4'hF);
    wr(14'h3FFF, 16'hA5C3, 4'hF);
    rd(14'h0000);
    checks++;
    if (dout !== 16'h1234) begin errors++; $display("FAIL full_rd_lo got %h expected 1234", dout); end
    rd(14'h3FFF);
    checks++;
    if (dout !== 16'hA5C3) begin errors++; $display("FAIL full_rd_hi got %h expected a5c3", dout); end
  endtask

  task automatic test_nibble_mask;
    wr(14'h0100, 16'hFFFF, 4'hF);
    wr(14'h0100, 16'h0000, 4'b0101);
    rd(14'h0100);
    checks++;
    if (dout !== 16'hF0F0) begin errors++; $display("FAIL mask_0101 got %h expected f0f0", dout); end
    wr(14'h0100, 16'h1234, 4'b0000);
    rd(14'h0100);
    checks++;
    if (dout !== 16'hF0F0) begin errors++; $display("FAIL mask_0000 got %h expected f0f0", dout); end
    wr(14'h0101, 16'h0000, 4'hF);
    wr(14'h0101, 16'hABCD, 4'b1010);
    rd(14'h0101);
    checks++;
    if (dout !== 16'hA0C0) begin errors++; $display("FAIL mask_1010 got %h expected a0c0", dout); end
  endtask

  task automatic test_write_hold;
    rd(14'h0000);
    checks++;
    if (dout !== 16'h1234) begin errors++; $display("FAIL hold_pre got %h expected 1234", dout); end
    wr(14'h0000, 16'h9999, 4'hF);
    checks++;
    if (dout !== 16'h1234) begin errors++; $display("FAIL hold_write got %h expected 1234", dout); end
    rd(14'h0000);
    checks++;
    if (dout !== 16'h9999) begin errors++; $display("FAIL hold_after got %h expected 9999", dout); end
  endtask

  task automatic test_low_power;
    rd(14'h0100);
    checks++;
    if (dout !== 16'hF0F0) begin errors++; $display("FAIL lp_pre got %h expected f0f0", dout); end
    step(1, 0, 1, 0, 0, 1, 14'h0100, 16'h0000, 4'hF);
    checks++;
    if (dout !== 16'hF0F0) begin errors++; $display("FAIL lp_cs0 got %h expected f0f0", dout); end
    step(1, 1, 1, 1, 0, 1, 14'h0100, 16'h0000, 4'hF);
    checks++;
    if (dout !== 16'hF0F0) begin errors++; $display("FAIL lp_standby got %h expected f0f0", dout); end
    step(1, 1, 1, 0, 1, 1, 14'h0100, 16'h0000, 4'hF);
    checks++;
    if (dout !== 16'h0000) begin errors++; $display("FAIL lp_sleep got %h expected 0000", dout); end
    step(1, 0, 0, 0, 0, 1, 14'h0100, 16'h0000, 4'h0);
    checks++;
    if (dout !== 16'h0000) begin errors++; $display("FAIL lp_wake_hold got %h expected 0000", dout); end
    rd(14'h0100);
    checks++;
    if (dout !== 16'hF0F0) begin errors++; $display("FAIL lp_retain got %h expected f0f0", dout); end
  endtask

  task automatic test_back_to_back;
    for (int a = 16'h10; a <= 16'h1F; a++) wr(a[13:0], a[15:0], 4'hF);
    for (int a = 16'h10; a <= 16'h1F; a++) begin
      rd(a[13:0]);
      checks++;
      if (dout !== a[15:0]) begin
        errors++;
        $display("FAIL b2b addr %h got %h expected %h", a[13:0], dout, a[15:0]);
      end
    end
  endtask

  task automatic test_random;
    logic [13:0] a;
    for (int n = 0; n < 400; n++) begin
      // Mostly a small window so writes and reads collide; occasionally anywhere.
      a = ($urandom_range(0, 7) == 0) ? 14'($urandom) : 14'($urandom_range(0, 31));
      step(($urandom_range(0, 31) != 0), ($urandom_range(0, 7) != 0), $urandom_range(0, 1),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0), 1'b1,
           a, 16'($urandom), 4'($urandom));
      checks++;
      if (dout !== exp_dout) begin
        errors++;
        $display("FAIL random cycle %0d got %h expected %h", n, dout, exp_dout);
      end
    end
  endtask

  // Last: contents are not checked after a power-off.
  task automatic test_poweroff;
    wr(14'h0020, 16'h5A5A, 4'hF);
    rd(14'h0020);
    checks++;
    if (dout !== 16'h5A5A) begin errors++; $display("FAIL po_pre got %h expected 5a5a", dout); end
    step(1, 1, 0, 0, 0, 0, 14'h0020, 16'h0000, 4'h0);
    checks++;
    if (dout !== 16'h0000) begin errors++; $display("FAIL po_off got %h expected 0000", dout); end
    step(1, 0, 0, 0, 0, 1, 14'h0020, 16'h0000, 4'h0);
    checks++;
    if (dout !== 16'h0000) begin errors++; $display("FAIL po_hold got %h expected 0000", dout); end
  endtask

  initial begin
    test_reset;
    test_full_rw;
    test_nibble_mask;
    test_write_hold;
    test_low_power;
    test_back_to_back;
    test_random;
    test_poweroff;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
